cic3_dec_ctrl: RTL and testbench
================================

CIC3_DEC_CTRL -- requirements
Module: cic3_dec_ctrl

Interface
REQ-001 The block SHALL have parameter DECIMATION_FACTOR, default 256, giving the decimation ratio D; it SHALL be a power of two, 4 or greater.
REQ-002 The block SHALL have parameter CLOCK_WIDTH, default $clog2(DECIMATION_FACTOR), giving the decimation counter width.
REQ-003 The block SHALL have parameter NUMBITS, default 3*CLOCK_WIDTH+1, giving the filter output word width.
REQ-004 The block SHALL have parameter SETTLE_SAMPLES, default 3, giving the number of decimated samples discarded after each start; it SHALL be 1 or greater.
REQ-005 The block SHALL have a single clock, clk, and a synchronous, active-high reset, reset: clk input 1, the high-speed modulator clock; reset input 1, synchronous, active-high.
REQ-006 The block SHALL have the following control and filter ports:
- start input 1: one-cycle request to begin conversion.
- stop input 1: one-cycle request to end conversion.
- filt_out input NUMBITS: the output word from the CIC3 filter.
- divided_clk output 1: the decimated clock driven to the filter.
- filt_reset_n output 1: active-low reset driven to the filter.
REQ-007 The block SHALL have the following data and status ports:
- data_out output NUMBITS: the held decimated sample.
- data_valid output 1: data_out holds an unconsumed sample.
- data_ready input 1: the consumer accepts the sample.
- sample_count output 16: the number of samples loaded.
- overrun output 1: sticky, a sample was lost.
- state output 2: the current FSM state.

Function
REQ-010 The FSM SHALL have states IDLE=0, SETTLE=1, RUN=2 and DRAIN=3.
REQ-011 In IDLE: cnt=0, divided_clk=0, filt_reset_n=0, and no capture strobes occur.
REQ-012 In IDLE, start SHALL cause the next state to be SETTLE, with cnt=0, filt_reset_n=1, the settle counter loaded with SETTLE_SAMPLES, wrap_seen=0, overrun cleared and sample_count cleared.
REQ-013 start outside IDLE SHALL be ignored, and stop in IDLE SHALL be ignored; if start and stop are both asserted in IDLE, start wins.
REQ-014 In SETTLE and RUN, cnt SHALL increment by 1 each cycle, modulo D; divided_clk SHALL equal cnt[CLOCK_WIDTH-1], registered and aligned with cnt; filter output updates on the falling edge at wrap D-1 to 0.
REQ-015 wrap_seen SHALL set on the first wrap of cnt from D-1 to 0.
REQ-016 The capture strobe SHALL assert in a cycle where cnt==2 and wrap_seen==1.
REQ-017 Each strobe in SETTLE SHALL decrement the settle counter and SHALL discard filt_out; the strobe that brings the counter to 0 SHALL cause the next state to be RUN.
REQ-018 Each strobe in RUN SHALL perform a load; a load is accepted when data_valid==0, or when data_valid&&data_ready in the same cycle. An accepted load SHALL set data_out=filt_out and data_valid=1 at the end of the strobe cycle, and sample_count SHALL increment, wrapping from 0xFFFF to 0.
REQ-019 A strobe with data_valid==1 and data_ready==0 SHALL set overrun=1; the new sample SHALL be dropped, the old sample retained, and sample_count left unchanged.
REQ-020 data_valid SHALL clear after data_valid&&data_ready unless a load occurs in the same cycle.
REQ-021 stop in SETTLE or RUN SHALL cause the next state to be DRAIN; a strobe in the same cycle as stop SHALL be discarded.
REQ-022 In DRAIN: cnt and divided_clk are frozen, no strobes occur, and filt_reset_n=1. DRAIN SHALL go to IDLE in the cycle after data_valid==0.
REQ-023 On entry to IDLE, divided_clk may fall; the filter is reset in the same cycle.
REQ-024 overrun SHALL clear only on reset or on an accepted start.
REQ-025 Strobe-to-data_valid latency SHALL be 1 cycle.

Reset
REQ-030 When reset is high at a clk edge, the block SHALL set:
- state=IDLE, cnt=0, wrap_seen=0, settle counter=0;
- divided_clk=0, filt_reset_n=0;
- data_out=0, data_valid=0, sample_count=0, overrun=0.
REQ-031 Reset SHALL override start, stop and data_ready, including mid-SETTLE, mid-RUN and mid-DRAIN.
REQ-032 Conversion after reset SHALL require a new start.

Structure
REQ-040 Package cic3_pkg SHALL hold the state enum (2-bit), the CAPTURE_PHASE=2 constant, and the default SETTLE_SAMPLES.
REQ-041 Sub-module cic3_dec_counter SHALL hold cnt, wrap_seen and the divided_clk register, with enable and clear inputs and a strobe output.
REQ-042 The FSM, the holding register and the status logic SHALL reside in cic3_dec_ctrl.

Verification (D=8, SETTLE_SAMPLES=3; cycle k = k-th cycle in SETTLE, cnt=k mod 8)
REQ-050 Start, data_ready=1: strobes at cycles 10, 18 and 26 are discarded and state becomes RUN after 26; data_out=filt_out sampled at cycle 34; data_valid=1 from cycle 35; sample_count=1.
REQ-051 RUN with data_ready=0 across two strobes: first sample held; overrun=1 after the second strobe; sample_count unchanged at 1; a subsequent start clears overrun.
REQ-052 Strobe with data_valid=1 and data_ready=1 in the same cycle: new word loaded, data_valid stays 1, no overrun.
REQ-053 stop in RUN with data_valid=1 and data_ready=0 for 5 cycles: state=DRAIN, cnt frozen; after data_ready, state=IDLE the following cycle and filt_reset_n=0.
REQ-054 reset asserted mid-RUN with cnt=5 and data_valid=1: all outputs at reset values the next cycle; start and stop ignored while reset is high.
REQ-055 start and stop asserted together in IDLE: SETTLE entered; stop in IDLE alone: no state change.

Source files
------------

// File: rtl/cic3_pkg.sv
// Shared types and constants for the CIC3 decimation controller.
package cic3_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  // Count value at which the filter output has settled after the falling edge of divided_clk.
  localparam int CAPTURE_PHASE          = 2;
  localparam int DEFAULT_SETTLE_SAMPLES = 3;
endpackage

// File: rtl/cic3_dec_counter.sv
// Decimation counter: free-runs modulo 2**CLOCK_WIDTH while enabled and
// produces the registered divided clock and the sample capture strobe.
module cic3_dec_counter
  import cic3_pkg::*;
#(
  parameter int CLOCK_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic divided_clk,
  output logic strobe
);
  logic [CLOCK_WIDTH-1:0] cnt;
  logic [CLOCK_WIDTH-1:0] cnt_next;
  logic                   wrap_seen;

  assign cnt_next = cnt + CLOCK_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt         <= '0;
      wrap_seen   <= 1'b0;
      divided_clk <= 1'b0;
    end else if (en) begin
      cnt         <= cnt_next;
      divided_clk <= cnt_next[CLOCK_WIDTH-1];
      if (&cnt) wrap_seen <= 1'b1;
    end
  end

  // The first partial period after a start carries no valid filter word.
  assign strobe = en && wrap_seen && (cnt == CLOCK_WIDTH'(CAPTURE_PHASE));
endmodule

// File: rtl/cic3_dec_ctrl.sv
// CIC3 decimation controller: sequences filter reset, discards settling
// samples, and hands decimated words to a consumer with overrun tracking.
module cic3_dec_ctrl
  import cic3_pkg::*;
#(
  parameter int DECIMATION_FACTOR = 256,
  parameter int CLOCK_WIDTH       = $clog2(DECIMATION_FACTOR),
  parameter int NUMBITS           = 3*CLOCK_WIDTH+1,
  parameter int SETTLE_SAMPLES    = DEFAULT_SETTLE_SAMPLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [NUMBITS-1:0] filt_out,
  output logic               divided_clk,
  output logic               filt_reset_n,
  output logic [NUMBITS-1:0] data_out,
  output logic               data_valid,
  input  logic               data_ready,
  output logic [15:0]        sample_count,
  output logic               overrun,
  output logic [1:0]         state
);
  localparam int SW = $clog2(SETTLE_SAMPLES+1);

  if (DECIMATION_FACTOR < 4 || (DECIMATION_FACTOR & (DECIMATION_FACTOR-1)) != 0 ||
      SETTLE_SAMPLES < 1) begin : g_bad_param
    $error("cic3_dec_ctrl: illegal DECIMATION_FACTOR or SETTLE_SAMPLES");
  end

  state_t        state_q;
  logic [SW-1:0] settle_cnt;
  logic          strobe;
  logic          count_en;
  logic          count_clr;
  logic          run_strobe;
  logic          load;
  logic          lost;

  assign state      = state_q;
  assign count_en   = (state_q == SETTLE) || (state_q == RUN);
  assign count_clr  = (state_q == IDLE) || (state_q == DRAIN && !data_valid);
  assign run_strobe = strobe && (state_q == RUN) && !stop;
  assign load       = run_strobe && (!data_valid || data_ready);
  assign lost       = run_strobe && data_valid && !data_ready;

  cic3_dec_counter #(.CLOCK_WIDTH(CLOCK_WIDTH)) u_counter (
    .clk         (clk),
    .reset       (reset),
    .en          (count_en),
    .clr         (count_clr),
    .divided_clk (divided_clk),
    .strobe      (strobe)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      settle_cnt   <= '0;
      filt_reset_n <= 1'b0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      sample_count <= '0;
      overrun      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q      <= SETTLE;
          settle_cnt   <= SW'(SETTLE_SAMPLES);
          filt_reset_n <= 1'b1;
          overrun      <= 1'b0;
          sample_count <= '0;
        end
        SETTLE: begin
          if (stop) begin
            state_q <= DRAIN;
          end else if (strobe) begin
            settle_cnt <= settle_cnt - SW'(1);
            if (settle_cnt == SW'(1)) state_q <= RUN;
          end
        end
        RUN: if (stop) state_q <= DRAIN;
        DRAIN: if (!data_valid) begin
          state_q      <= IDLE;
          filt_reset_n <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase

      if (load) begin
        data_out     <= filt_out;
        data_valid   <= 1'b1;
        sample_count <= sample_count + 16'd1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
      if (lost) overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cic3_dec_ctrl.sv
// Directed bench for cic3_dec_ctrl with D=8, three settle samples.
module tb_cic3_dec_ctrl;
  localparam int D  = 8;
  localparam int CW = 3;
  localparam int NB = 10;
  localparam int SS = 3;

  logic          clk = 1'b0;
  logic          reset, start, stop, data_ready;
  logic [NB-1:0] filt_out;
  logic          divided_clk, filt_reset_n, data_valid, overrun;
  logic [NB-1:0] data_out;
  logic [15:0]   sample_count;
  logic [1:0]    state;

  cic3_dec_ctrl #(
    .DECIMATION_FACTOR (D),
    .CLOCK_WIDTH       (CW),
    .NUMBITS           (NB),
    .SETTLE_SAMPLES    (SS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .filt_out     (filt_out),
    .divided_clk  (divided_clk),
    .filt_reset_n (filt_reset_n),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .sample_count (sample_count),
    .overrun      (overrun),
    .state        (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rdy_before;
    logic          rdy_strobe;
    logic [NB-1:0] filt;
    logic          exp_dv;
    logic [NB-1:0] exp_data;
    logic [15:0]   exp_count;
    logic          exp_ovr;
  } vec_t;

  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;
  int   k      = 0;

  function automatic logic [NB-1:0] fval(input int c);
    return NB'((c * 37 + 5) & 1023);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
    filt_out = fval(k);
  endtask

  task automatic go_to(input int target);
    while (k < target) step();
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_dclk"}, 32'(divided_clk), 0);
    chk({tag, "_frn"}, 32'(filt_reset_n), 0);
    chk({tag, "_dv"}, 32'(data_valid), 0);
    chk({tag, "_data"}, 32'(data_out), 0);
    chk({tag, "_count"}, 32'(sample_count), 0);
    chk({tag, "_ovr"}, 32'(overrun), 0);
  endtask

  initial begin
    // per-strobe RUN vectors, strobes at cycles 42, 50, 58, 66, 74
    vecs[0] = '{1'b1, 1'b0, 10'h155, 1'b1, 10'h155, 16'd2, 1'b0}; // consumed earlier, load
    vecs[1] = '{1'b0, 1'b1, 10'h2F0, 1'b1, 10'h2F0, 16'd3, 1'b0}; // ready on strobe: reload
    vecs[2] = '{1'b0, 1'b0, 10'h0AA, 1'b1, 10'h2F0, 16'd3, 1'b1}; // not consumed: overrun
    vecs[3] = '{1'b1, 1'b0, 10'h3C3, 1'b1, 10'h3C3, 16'd4, 1'b1}; // load, overrun sticky
    vecs[4] = '{1'b0, 1'b0, 10'h001, 1'b1, 10'h3C3, 16'd4, 1'b1}; // dropped again

    reset = 1'b1; start = 1'b0; stop = 1'b0; data_ready = 1'b0; filt_out = '0;
    step();
    step();
    chk_reset_vals("reset");

    reset = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_idle_state", 32'(state), 0);

    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    k = 0;
    chk("start_stop_state", 32'(state), 1);
    chk("settle_frn", 32'(filt_reset_n), 1);
    chk("settle_dclk0", 32'(divided_clk), 0);

    data_ready = 1'b1;
    go_to(3);  chk("dclk_c3", 32'(divided_clk), 0);
    go_to(4);  chk("dclk_c4", 32'(divided_clk), 1);
    go_to(26); chk("state_c26", 32'(state), 1);
    go_to(27); chk("state_c27", 32'(state), 2);
    go_to(34); chk("dv_c34", 32'(data_valid), 0);
    go_to(35);
    chk("dv_c35", 32'(data_valid), 1);
    chk("data_c35", 32'(data_out), 32'(fval(34)));
    chk("count_c35", 32'(sample_count), 1);

    for (int i = 0; i < 5; i++) begin
      data_ready = vecs[i].rdy_before;
      go_to(42 + 8 * i);
      data_ready = vecs[i].rdy_strobe;
      filt_out   = vecs[i].filt;
      step();
      chk($sformatf("vec%0d_dv", i), 32'(data_valid), 32'(vecs[i].exp_dv));
      chk($sformatf("vec%0d_data", i), 32'(data_out), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d_count", i), 32'(sample_count), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_ovr", i), 32'(overrun), 32'(vecs[i].exp_ovr));
    end

    data_ready = 1'b0;
    go_to(77);
    chk("dclk_c77", 32'(divided_clk), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("drain_state", 32'(state), 3);
    chk("drain_dclk", 32'(divided_clk), 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("drain_hold%0d_state", i), 32'(state), 3);
      chk($sformatf("drain_hold%0d_dclk", i), 32'(divided_clk), 1);
      chk($sformatf("drain_hold%0d_dv", i), 32'(data_valid), 1);
    end
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;
    chk("drain_consumed_dv", 32'(data_valid), 0);
    chk("drain_consumed_state", 32'(state), 3);
    step();
    chk("idle_state", 32'(state), 0);
    chk("idle_frn", 32'(filt_reset_n), 0);
    chk("idle_dclk", 32'(divided_clk), 0);
    chk("idle_ovr_sticky", 32'(overrun), 1);
    chk("idle_count", 32'(sample_count), 4);

    do_start();
    chk("restart_ovr", 32'(overrun), 0);
    chk("restart_count", 32'(sample_count), 0);
    chk("restart_state", 32'(state), 1);

    // stop coinciding with the first RUN strobe discards it
    go_to(34);
    stop = 1'b1;
    filt_out = 10'h2AA;
    step();
    stop = 1'b0;
    chk("stop_strobe_state", 32'(state), 3);
    chk("stop_strobe_dv", 32'(data_valid), 0);
    chk("stop_strobe_count", 32'(sample_count), 0);
    step();
    chk("stop_strobe_idle", 32'(state), 0);

    // reset mid-RUN with a held sample
    do_start();
    go_to(35);
    chk("pre_reset_dv", 32'(data_valid), 1);
    go_to(37);
    reset = 1'b1; start = 1'b1; stop = 1'b1; data_ready = 1'b1;
    step();
    chk_reset_vals("midrun_reset");
    step();
    chk("reset_hold_state", 32'(state), 0);
    reset = 1'b0; start = 1'b0; stop = 1'b0; data_ready = 1'b0;
    step();
    chk("post_reset_state", 32'(state), 0);
    chk("post_reset_frn", 32'(filt_reset_n), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
